// File: rtl/receiver_spi.sv
// receiver_spi -- SPI slave clocked by the system clock.
//   SCK, CS and MOSI are oversampled through SYNC_STAGES-deep synchronisers.
//   SCK edges are found by comparing the synchronised SCK with a 1-cycle-delayed copy.
//   All four CKP/CPH modes are supported. CKP/CPH are latched on the CS falling edge.
//   Back-to-back frames are received while CS stays low.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous reset, active low
//   CKP, CPH  SPI mode (SCK idle level, sample phase)
//   SCK, CS, MOSI  master-side serial lines (asynchronous to clk)
//   data_in   word shifted out on MISO, loaded at frame start / frame completion
//   MISO      serial data to the master
//   data_out  last complete received word
//   rx_valid  1-cycle pulse when data_out updates
//   busy      transfer active (state != IDLE)
//
// Optional build macro: MISO_TRISTATE_EN -- MISO floats (1'bz) while IDLE.
module receiver_spi #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             CKP,
  input  logic             CPH,
  input  logic             SCK,
  input  logic             CS,
  input  logic             MOSI,
  input  logic [WIDTH-1:0] data_in,
  output logic             MISO,
  output logic [WIDTH-1:0] data_out,
  output logic             rx_valid,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                 state, state_nx;
  logic [SYNC_STAGES-1:0] sck_pipe, cs_pipe, mosi_pipe;
  logic                   sck_d, cs_d;
  logic                   sck_s, cs_s, mosi_s;
  logic                   ckp_r, cph_r, ckp_nx, cph_nx;
  logic [WIDTH-1:0]       shift_reg, shift_nx, data_out_nx;
  logic [CW-1:0]          bit_cnt, bit_cnt_nx;
  logic                   miso_q, miso_nx, rx_valid_nx;
  logic                   sck_rise, sck_fall, lead, trail, sample, shft, last_sample, cs_fall;

  // Synchronisers. CS resets high, so a CS that is already low when reset
  // releases is still seen as a falling edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sck_pipe  <= '0;
      cs_pipe   <= '1;
      mosi_pipe <= '0;
      sck_d     <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sck_pipe  <= {sck_pipe[SYNC_STAGES-2:0], SCK};
      cs_pipe   <= {cs_pipe[SYNC_STAGES-2:0], CS};
      mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], MOSI};
      sck_d     <= sck_s;
      cs_d      <= cs_s;
    end
  end

  assign sck_s  = sck_pipe[SYNC_STAGES-1];
  assign cs_s   = cs_pipe[SYNC_STAGES-1];
  assign mosi_s = mosi_pipe[SYNC_STAGES-1];

  assign sck_rise    = sck_s & ~sck_d;
  assign sck_fall    = ~sck_s & sck_d;
  assign lead        = ckp_r ? sck_fall : sck_rise;   // leaves idle level
  assign trail       = ckp_r ? sck_rise : sck_fall;   // returns to idle level
  assign sample      = cph_r ? trail : lead;
  assign shft        = cph_r ? lead  : trail;
  assign last_sample = sample && (bit_cnt == CW'(WIDTH - 1));
  assign cs_fall     = ~cs_s & cs_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      ckp_r     <= 1'b0;
      cph_r     <= 1'b0;
      shift_reg <= '0;
      bit_cnt   <= '0;
      data_out  <= '0;
      rx_valid  <= 1'b0;
      miso_q    <= 1'b0;
    end else begin
      state     <= state_nx;
      ckp_r     <= ckp_nx;
      cph_r     <= cph_nx;
      shift_reg <= shift_nx;
      bit_cnt   <= bit_cnt_nx;
      data_out  <= data_out_nx;
      rx_valid  <= rx_valid_nx;
      miso_q    <= miso_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    ckp_nx      = ckp_r;
    cph_nx      = cph_r;
    shift_nx    = shift_reg;
    bit_cnt_nx  = bit_cnt;
    data_out_nx = data_out;
    rx_valid_nx = 1'b0;
    miso_nx     = miso_q;
    case (state)
      IDLE: begin
        if (cs_fall) begin
          state_nx   = SHIFT;
          ckp_nx     = CKP;
          cph_nx     = CPH;
          shift_nx   = data_in;
          bit_cnt_nx = '0;
          if (!CPH) miso_nx = data_in[WIDTH-1];
        end
      end
      SHIFT: begin
        if (bit_cnt == CW'(WIDTH)) begin
          // Completion cycle: publish the word and reload for the next frame.
          data_out_nx = shift_reg;
          rx_valid_nx = 1'b1;
          shift_nx    = data_in;
          bit_cnt_nx  = '0;
          if (!cph_r) miso_nx = data_in[WIDTH-1];
          // CS already gone (it rose with or after the final sample edge).
          if (cs_s) begin
            state_nx = IDLE;
            miso_nx  = 1'b0;
          end
        end else if (cs_s && !last_sample) begin
          // Abort: drop the partial frame, data_out untouched.
          state_nx   = IDLE;
          bit_cnt_nx = '0;
          miso_nx    = 1'b0;
        end else if (sample) begin
          shift_nx   = {shift_reg[WIDTH-2:0], mosi_s};
          bit_cnt_nx = bit_cnt + 1'b1;
        end else if (shft && (cph_r || bit_cnt != '0)) begin
          // CPH=0: the MSB is already on MISO at bit_cnt 0, so the trailing
          // edge that follows the final sample (after reload) is skipped.
          miso_nx = shift_reg[WIDTH-1];
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

`ifdef MISO_TRISTATE_EN
  assign MISO = (state == IDLE) ? 1'bz : miso_q;
`else
  assign MISO = miso_q;
`endif

endmodule

// File: tb/tb_receiver_spi.sv
// Directed bench for receiver_spi: a master model drives SCK at clk/8 in all
// four modes, collects MISO, and every rx_valid cycle logs data_out.
module tb_receiver_spi;
  localparam int W = 8;

  logic         clk = 1'b0, rst = 1'b1;
  logic         CKP = 1'b0, CPH = 1'b0, SCK = 1'b0, CS = 1'b1, MOSI = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         MISO, rx_valid, busy;
  logic [W-1:0] data_out;

  int           total = 0, bad = 0;
  logic [W-1:0] m_rx, m_rx0;
  logic         m_ckp = 1'b0, m_cph = 1'b0;
  logic [W-1:0] rx_q[$];

  always #5 clk = ~clk;

  receiver_spi #(.WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .CKP(CKP), .CPH(CPH), .SCK(SCK), .CS(CS), .MOSI(MOSI),
    .data_in(data_in), .MISO(MISO), .data_out(data_out), .rx_valid(rx_valid), .busy(busy)
  );

  // One entry per rx_valid cycle, so queue size also checks pulse width.
  always @(negedge clk) if (rx_valid) rx_q.push_back(data_out);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] q_at(input int i);
    return (i < rx_q.size()) ? rx_q[i] : 8'hxx;
  endfunction

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_down(input logic ckp, input logic cph);
    m_ckp = ckp; m_cph = cph;
    CKP = ckp; CPH = cph; SCK = ckp;
    clks(4);
    CS = 1'b0;
    clks(4);
  endtask

  // Master side: bits hi..lo of w, SCK half period = 4 clk.
  task automatic bits(input logic [W-1:0] w, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      if (!m_cph) begin
        MOSI = w[i]; clks(4);
        m_rx[i] = MISO; SCK = ~m_ckp; clks(4);
        SCK = m_ckp;
      end else begin
        clks(4);
        SCK = ~m_ckp; MOSI = w[i]; clks(4);
        m_rx[i] = MISO; SCK = m_ckp;
      end
    end
  endtask

  task automatic cs_up();
    clks(4);
    CS = 1'b1;
    clks(8);
  endtask

  task automatic frame(input string tag, input logic ckp, input logic cph,
                       input logic [W-1:0] din, input logic [W-1:0] w);
    data_in = din;
    rx_q.delete();
    cs_down(ckp, cph);
    bits(w, W-1, 0);
    chk({tag, "_busy_hi"}, 32'(busy), 32'd1);
    cs_up();
    chk({tag, "_miso"}, 32'(m_rx), 32'(din));
    chk({tag, "_nvalid"}, 32'(rx_q.size()), 32'd1);
    chk({tag, "_dout"}, 32'(data_out), 32'(w));
    chk({tag, "_busy_lo"}, 32'(busy), 32'd0);
  endtask

  initial begin
    // Reset state
    #2 rst = 1'b0;
    #1;
    chk("rst_dout", 32'(data_out), 32'd0);
    chk("rst_valid", 32'(rx_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
`ifdef MISO_TRISTATE_EN
    chk("rst_miso", {31'd0, MISO}, {31'd0, 1'bz});
`else
    chk("rst_miso", {31'd0, MISO}, 32'd0);
`endif
    clks(3);
    rst = 1'b1;
    clks(4);

    // All four modes
    frame("m00", 1'b0, 1'b0, 8'hA5, 8'h3C);
    frame("m11", 1'b1, 1'b1, 8'h0F, 8'hF0);
    frame("m01", 1'b0, 1'b1, 8'h81, 8'h7E);
    frame("m10", 1'b1, 1'b0, 8'h81, 8'h7E);

    // Back-to-back frames, data_in swapped after the first load
    data_in = 8'hAA;
    rx_q.delete();
    cs_down(1'b0, 1'b0);
    data_in = 8'h55;
    bits(8'h12, W-1, 0);
    m_rx0 = m_rx;
    bits(8'h34, W-1, 0);
    cs_up();
    chk("b2b_miso0", 32'(m_rx0), 32'hAA);
    chk("b2b_miso1", 32'(m_rx), 32'h55);
    chk("b2b_nvalid", 32'(rx_q.size()), 32'd2);
    chk("b2b_dout0", 32'(q_at(0)), 32'h12);
    chk("b2b_dout1", 32'(q_at(1)), 32'h34);

    // Abort after 5 bits
    rx_q.delete();
    cs_down(1'b0, 1'b0);
    bits(8'hFF, W-1, W-5);
    cs_up();
    chk("abort_nvalid", 32'(rx_q.size()), 32'd0);
    chk("abort_dout", 32'(data_out), 32'h34);
    chk("abort_busy", 32'(busy), 32'd0);
    frame("post_abort", 1'b0, 1'b0, 8'h3C, 8'h96);

    // Reset mid-frame, between clk edges
    rx_q.delete();
    cs_down(1'b1, 1'b1);
    bits(8'h5A, W-1, W-3);
    #2 rst = 1'b0;
    #1;
    chk("mrst_dout", 32'(data_out), 32'd0);
    chk("mrst_valid", 32'(rx_valid), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
`ifdef MISO_TRISTATE_EN
    chk("mrst_miso", {31'd0, MISO}, {31'd0, 1'bz});
`else
    chk("mrst_miso", {31'd0, MISO}, 32'd0);
`endif
    CS = 1'b1;
    SCK = m_ckp;
    clks(4);
    rst = 1'b1;
    clks(4);
    chk("mrst_nvalid", 32'(rx_q.size()), 32'd0);
    frame("post_rst", 1'b1, 1'b1, 8'hC3, 8'h5A);

    // Mode lock: CKP input flips mid-frame, master stays in mode 00
    rx_q.delete();
    data_in = 8'h69;
    cs_down(1'b0, 1'b0);
    bits(8'hC3, W-1, W-3);
    CKP = 1'b1;
    CPH = 1'b1;
    bits(8'hC3, W-4, 0);
    cs_up();
    chk("lock_nvalid", 32'(rx_q.size()), 32'd1);
    chk("lock_dout", 32'(data_out), 32'hC3);
    chk("lock_miso", 32'(m_rx), 32'h69);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
